// File: rtl/riscv_dmem_arbiter_if.sv
// One master's request/response bundle toward the data-memory arbiter.
// Requester holds req until gnt; rvalid/rdata return one cycle after a read grant.
interface riscv_dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/riscv_dmem_arbiter.sv
// Data-memory arbiter: CPU fixed priority, loader forced in after MAX_WAIT denials; 0-cycle grant,
// 1-cycle read return to the issuing master; a denied master simply keeps req high.
module riscv_dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  riscv_dmem_arbiter_if.slave   cpu,
  riscv_dmem_arbiter_if.slave   ldr,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
  localparam int            CW      = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  typedef enum logic {CPU_PRI = 1'b0, LDR_PRI = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic          ldr_rvalid_q, ldr_rvalid_d;
  logic          cpu_gnt, ldr_gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= CPU_PRI;
      wait_cnt_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ldr_rvalid_q <= ldr_rvalid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      CPU_PRI: begin
        if (ldr_gnt || !ldr.req) begin
          wait_cnt_d = '0;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (wait_cnt_d == CNT_MAX) begin
          state_d = LDR_PRI;
        end
      end
      LDR_PRI: begin
        // Loader either takes its slot or has withdrawn, so priority lasts one cycle.
        wait_cnt_d = '0;
        state_d    = CPU_PRI;
      end
    endcase
  end

  always_comb begin
    cpu_gnt = 1'b0;
    ldr_gnt = 1'b0;
    if (rst_n) begin
      if (state_q == LDR_PRI) begin
        ldr_gnt = ldr.req;
        cpu_gnt = cpu.req & ~ldr.req;
      end else begin
        cpu_gnt = cpu.req;
        ldr_gnt = ldr.req & ~cpu.req;
      end
    end
    mem_addr_o   = ldr_gnt ? ldr.addr  : cpu.addr;
    mem_wdata_o  = ldr_gnt ? ldr.wdata : cpu.wdata;
    mem_we_o     = ldr_gnt ? ldr.we    : (cpu_gnt & cpu.we);
    cpu_rvalid_d = cpu_gnt & ~cpu.we;
    ldr_rvalid_d = ldr_gnt & ~ldr.we;
  end

  // A read issued just before reset must not surface during the reset cycle.
  assign cpu.gnt    = cpu_gnt;
  assign cpu.rvalid = cpu_rvalid_q & rst_n;
  assign cpu.rdata  = mem_rdata_i;
  assign ldr.gnt    = ldr_gnt;
  assign ldr.rvalid = ldr_rvalid_q & rst_n;
  assign ldr.rdata  = mem_rdata_i;
endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Bench for riscv_dmem_arbiter: directed stimulus, a bench-side synchronous memory,
// and a starvation-count reference model checked every cycle at the falling edge.
module tb_riscv_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cpu_if ();
  riscv_dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ldr_if ();

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  riscv_dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu         (cpu_if),
    .ldr         (ldr_if),
    .mem_addr_o  (mem_addr),
    .mem_we_o    (mem_we),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Unwritten locations read back a pattern derived from their address.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  logic [DW-1:0] env_mem [logic [AW-1:0]];
  always @(posedge clk) begin
    mem_rdata = env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_val(mem_addr);
    if (mem_we) env_mem[mem_addr] = mem_wdata;
  end

  // Reference model: who wins this cycle follows from the loader's consecutive denials.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            denied = 0;
  logic          pend_cpu = 1'b0, pend_ldr = 1'b0;
  logic [DW-1:0] pend_data = '0;
  logic          m_cg, m_lg, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_lg = 1'b0;
      m_cg = 1'b0;
    end else begin
      m_lg = ldr_if.req && (denied >= MW || !cpu_if.req);
      m_cg = cpu_if.req && !m_lg;
    end
    m_we   = m_lg ? ldr_if.we    : (m_cg && cpu_if.we);
    m_addr = m_lg ? ldr_if.addr  : cpu_if.addr;
    m_wd   = m_lg ? ldr_if.wdata : cpu_if.wdata;

    chk("model cpu_gnt", cpu_if.gnt, m_cg);
    chk("model ldr_gnt", ldr_if.gnt, m_lg);
    chk("model mem_we", mem_we, m_we);
    chk("model mem_addr", mem_addr, m_addr);
    if (m_we) chk("model mem_wdata", mem_wdata, m_wd);
    chk("model cpu_rvalid", cpu_if.rvalid, rst_n && pend_cpu);
    chk("model ldr_rvalid", ldr_if.rvalid, rst_n && pend_ldr);
    if (rst_n && pend_cpu) chk("model cpu_rdata", cpu_if.rdata, pend_data);
    if (rst_n && pend_ldr) chk("model ldr_rdata", ldr_if.rdata, pend_data);

    pend_cpu = m_cg && !cpu_if.we;
    pend_ldr = m_lg && !ldr_if.we;
    if (pend_cpu || pend_ldr)
      pend_data = ref_mem.exists(m_addr) ? ref_mem[m_addr] : init_val(m_addr);
    if (m_we) ref_mem[m_addr] = m_wd;
    if (!rst_n || m_lg || !ldr_if.req) denied = 0;
    else if (denied < MW) denied++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
    ldr_if.req = 1'b0; ldr_if.we = 1'b0; ldr_if.addr = '0; ldr_if.wdata = '0;
  endtask

  task automatic cpu_drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_if.req = 1'b1; cpu_if.we = we; cpu_if.addr = a; cpu_if.wdata = d;
  endtask

  task automatic ldr_drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ldr_if.req = 1'b1; ldr_if.we = we; ldr_if.addr = a; ldr_if.wdata = d;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    cpu_drive(1'b0, 32'h0000_0100, '0);
    ldr_drive(1'b0, 32'h0000_0200, '0);
    repeat (2) begin
      mid();
      chk("reset cpu_gnt", cpu_if.gnt, 1'b0);
      chk("reset ldr_gnt", ldr_if.gnt, 1'b0);
      chk("reset mem_we", mem_we, 1'b0);
      chk("reset cpu_rvalid", cpu_if.rvalid, 1'b0);
      chk("reset ldr_rvalid", ldr_if.rvalid, 1'b0);
      tick();
    end
    rst_n = 1'b1;
    mid();
    chk("release cpu_gnt", cpu_if.gnt, 1'b1);
    chk("release ldr_gnt", ldr_if.gnt, 1'b0);
    tick();
    idle();
    mid();
    chk("release cpu_rvalid", cpu_if.rvalid, 1'b1);
    chk("release cpu_rdata", cpu_if.rdata, 32'hA5A5_5B5A);
    tick();

    cpu_drive(1'b1, 32'h0080_0010, 32'hDEAD_BEEF);
    mid();
    chk("cpu wr mem_we", mem_we, 1'b1);
    chk("cpu wr mem_addr", mem_addr, 32'h0080_0010);
    chk("cpu wr mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    cpu_drive(1'b0, 32'h0080_0010, '0);
    mid();
    chk("cpu rd mem_we", mem_we, 1'b0);
    chk("cpu rd cpu_gnt", cpu_if.gnt, 1'b1);
    chk("cpu rd no early rvalid", cpu_if.rvalid, 1'b0);
    tick();
    idle();
    mid();
    chk("cpu rd rvalid", cpu_if.rvalid, 1'b1);
    chk("cpu rd rdata", cpu_if.rdata, 32'hDEAD_BEEF);
    chk("cpu rd ldr_rvalid", ldr_if.rvalid, 1'b0);
    tick();
    mid();
    chk("cpu rd rvalid drops", cpu_if.rvalid, 1'b0);
    tick();

    for (int i = 0; i < 8; i++) begin
      ldr_drive(1'b0, 32'h0000_1000 + 32'(4 * i), '0);
      mid();
      chk("ldr burst gnt", ldr_if.gnt, 1'b1);
      chk("ldr burst cpu_rvalid", cpu_if.rvalid, 1'b0);
      if (i > 0) begin
        chk("ldr burst rvalid", ldr_if.rvalid, 1'b1);
        chk("ldr burst rdata", ldr_if.rdata, (32'h0000_1000 + 32'(4 * (i - 1))) ^ 32'hA5A5_5A5A);
      end
      tick();
    end
    idle();
    mid();
    chk("ldr burst last rvalid", ldr_if.rvalid, 1'b1);
    chk("ldr burst last rdata", ldr_if.rdata, 32'hA5A5_4A46);
    tick();
    mid();
    chk("ldr burst rvalid drops", ldr_if.rvalid, 1'b0);
    tick();

    cpu_drive(1'b0, 32'h0000_2000, '0);
    ldr_drive(1'b0, 32'h0000_3000, '0);
    for (int k = 0; k < 10; k++) begin
      mid();
      chk("contend cpu_gnt", cpu_if.gnt, (k % 5) != 4);
      chk("contend ldr_gnt", ldr_if.gnt, (k % 5) == 4);
      tick();
    end
    idle();
    tick();

    cpu_drive(1'b0, 32'h0080_0010, '0);
    mid();
    tick();
    cpu_if.req = 1'b0;
    ldr_drive(1'b0, 32'h0000_1004, '0);
    mid();
    chk("switch cpu_rvalid", cpu_if.rvalid, 1'b1);
    chk("switch cpu_rdata", cpu_if.rdata, 32'hDEAD_BEEF);
    chk("switch ldr_gnt", ldr_if.gnt, 1'b1);
    chk("switch ldr_rvalid early", ldr_if.rvalid, 1'b0);
    tick();
    idle();
    mid();
    chk("switch ldr_rvalid", ldr_if.rvalid, 1'b1);
    chk("switch ldr_rdata", ldr_if.rdata, 32'hA5A5_4A5E);
    chk("switch cpu_rvalid off", cpu_if.rvalid, 1'b0);
    tick();

    ldr_drive(1'b1, 32'h0000_1008, 32'h1234_5678);
    mid();
    chk("ldr wr mem_we", mem_we, 1'b1);
    chk("ldr wr mem_wdata", mem_wdata, 32'h1234_5678);
    tick();
    idle();
    cpu_drive(1'b0, 32'h0000_1008, '0);
    mid();
    chk("ldr wr no rvalid", ldr_if.rvalid, 1'b0);
    tick();
    idle();
    mid();
    chk("cross rd rdata", cpu_if.rdata, 32'h1234_5678);
    tick();

    ldr_drive(1'b0, 32'h0000_1010, '0);
    mid();
    chk("pre-reset ldr_gnt", ldr_if.gnt, 1'b1);
    tick();
    idle();
    rst_n = 1'b0;
    cpu_drive(1'b1, 32'h0080_0010, 32'hBAD0_BAD0);
    mid();
    chk("midreset ldr_rvalid", ldr_if.rvalid, 1'b0);
    chk("midreset mem_we", mem_we, 1'b0);
    chk("midreset cpu_gnt", cpu_if.gnt, 1'b0);
    tick();
    rst_n = 1'b1;
    idle();
    mid();
    chk("postreset ldr_rvalid", ldr_if.rvalid, 1'b0);
    tick();
    cpu_drive(1'b0, 32'h0080_0010, '0);
    ldr_drive(1'b0, 32'h0000_3000, '0);
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("postreset ldr_gnt", ldr_if.gnt, k == 4);
      if (k == 4) chk("suppressed write", cpu_if.rdata, 32'hDEAD_BEEF);
      tick();
    end
    idle();
    mid();
    chk("postreset ldr_rvalid", ldr_if.rvalid, 1'b1);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
